vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Single-clock VGA raster timing generator, the producing end of the `horizCounter`/`vertCounter` interface that the clock renderer consumes. It drives the raster counters and the line/frame strobes, and emits the periodic refresh request that retriggers the renderer's redraw. It also aligns the renderer's registered `pixel_bw` with delayed sync and blanking to drive the VGA pins.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal porch and sync widths; H_TOTAL = sum = 800
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical porch and sync widths; V_TOTAL = 525
- `SYNC_POL`, 0: pin level during the sync pulse (0 = active-low)
- `REFRESH_FRAMES`, 60: frames per refresh request, range 1..63
- `FG_RGB`, 6'b111111 / `BG_RGB`, 6'b000000: {r[1:0],g[1:0],b[1:0]} for pixel 1 / 0
- `clk` input 1: pixel clock; all state on its rising edge
- `reset` input 1: synchronous, active-high
- `pixel_in` input 1: renderer pixel; valid exactly one cycle after the counters it was computed from
- `horizCounter` output 10: current column, 0..H_TOTAL-1
- `vertCounter` output 10: current line, 0..V_TOTAL-1
- `display_on` output 1: counters inside the active area (combinational decode)
- `line_start` output 1: one-cycle strobe at horizCounter==0
- `frame_start` output 1: one-cycle strobe at (0,0)
- `refresh_req` output 1: renderer retrigger (feeds `slow_clk`)
- `vga_hs`, `vga_vs` output 1: sync pins, registered
- `vga_r`, `vga_g`, `vga_b` output 2 each: colour pins, registered

## Operation
- Counters: `horizCounter` +1 per cycle; at H_TOTAL-1 it wraps to 0 and `vertCounter` +1. `vertCounter` wraps V_TOTAL-1 → 0 on the same edge that `horizCounter` wraps.
- Decodes, combinational from the counter registers:
  - `display_on` = h < H_ACTIVE && v < V_ACTIVE
  - hsync_raw = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751)
  - vsync_raw = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491)
- `line_start`, `frame_start`: decode ANDed with ~reset. Both are 0 while reset is high.
- Frame counter (6 bit): increments on the cycle with h==H_TOTAL-1 && v==V_TOTAL-1. It wraps from REFRESH_FRAMES-1 to 0. With REFRESH_FRAMES=1 it stays at 0.
- `refresh_req` = (frame_cnt == REFRESH_FRAMES-1) && (v == V_ACTIVE) && ~reset.
  - This gives one full blank line, H_TOTAL cycles high, once per REFRESH_FRAMES frames.
  - The level falls before the next active area, so the renderer's inhibit re-arms.
- Output pipeline, two register stages. Stage 1 delays de/hs/vs by one cycle. Stage 2:
  - `vga_hs` = hs_d1 ? SYNC_POL : ~SYNC_POL (same rule for `vga_vs`)
  - {`vga_r`,`vga_g`,`vga_b`} = de_d1 ? (`pixel_in` ? FG_RGB : BG_RGB) : 6'b0
- `pixel_in` is ignored whenever de_d1 = 0 (blanking forces black).

## Timing
- Reset, while `reset` is high:
  - counters = 0, frame_cnt = 0
  - pipeline de/hs/vs = 0
  - `vga_hs` = `vga_vs` = ~SYNC_POL, RGB = 0
  - `line_start` = `frame_start` = `refresh_req` = 0
  - `display_on` = 1 (it decodes (0,0))
- First cycle after release: counters (0,0), `frame_start` = `line_start` = 1. Next cycle h = 1.
- Reset asserted mid-frame: on the next edge counters, frame_cnt and pipeline clear. There is no partial-line completion.
- Pin latency: 2 cycles from counter value to the sync and RGB pins. `pixel_in` sampled at cycle t+1 corresponds to counters at t and appears on RGB at t+2.
- Hsync pin active for exactly H_SYNC consecutive cycles per line. Vsync pin active for V_SYNC×H_TOTAL cycles, starting 2 cycles after h==0 of line 490.
- Frame period H_TOTAL×V_TOTAL = 420000 cycles. Refresh period REFRESH_FRAMES× that.

## Test plan
- Reset/release: hold reset 5 cycles and check every output at its reset value. Release; `frame_start`=1 on the first cycle only; h reaches 799 at cycle 799, then (0,1) with `line_start`=1.
- Hsync: `vga_hs` goes low at the edge where h==658, held 96 cycles, high when h==754. No hsync in any other column.
- Vsync and frame wrap: `vga_vs` low for 1600 cycles from line 490. Counters go (799,524) → (0,0) with `frame_start`=1.
- Pixel alignment: drive `pixel_in`=1 only in the cycle after h==5, v==10. RGB=6'b111111 only at h==7, v==10, else 0. Drive `pixel_in`=1 constantly: RGB=0 for columns 640..799 (delayed by 2) and lines 480..524.
- Refresh: with REFRESH_FRAMES=2, `refresh_req` high for exactly 800 cycles at v==480 of frames 1, 3, 5…, never in frames 0, 2, 4.
- Mid-frame reset at (300,200) for 1 cycle: next cycle counters (0,0), sync pins inactive, frame_cnt restarts so the next `refresh_req` follows REFRESH_FRAMES full frames later.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster bus shared by the timing generator, the clock renderer and the VGA pin driver.
// Counter names keep the renderer's existing horizCounter/vertCounter spelling.
interface vga_timing_gen_if;
    logic       pixel_in;
    logic [9:0] horizCounter;
    logic [9:0] vertCounter;
    logic       display_on;
    logic       line_start;
    logic       frame_start;
    logic       refresh_req;
    logic       vga_hs;
    logic       vga_vs;
    logic [1:0] vga_r;
    logic [1:0] vga_g;
    logic [1:0] vga_b;

    // Timing generator side: owns the counters, strobes and pins.
    modport master (
        input  pixel_in,
        output horizCounter, vertCounter, display_on, line_start, frame_start,
        output refresh_req, vga_hs, vga_vs, vga_r, vga_g, vga_b
    );

    // Renderer / board side: supplies the pixel, observes everything else.
    modport slave (
        output pixel_in,
        input  horizCounter, vertCounter, display_on, line_start, frame_start,
        input  refresh_req, vga_hs, vga_vs, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: column/line counters, line/frame strobes, periodic
// renderer refresh request, and a two-stage pipeline aligning pixel_in with sync/blank.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE       = 640,
    parameter int unsigned H_FP           = 16,
    parameter int unsigned H_SYNC         = 96,
    parameter int unsigned H_BP           = 48,
    parameter int unsigned V_ACTIVE       = 480,
    parameter int unsigned V_FP           = 10,
    parameter int unsigned V_SYNC         = 2,
    parameter int unsigned V_BP           = 33,
    parameter logic        SYNC_POL       = 1'b0,
    parameter int unsigned REFRESH_FRAMES = 60,
    parameter logic [5:0]  FG_RGB         = 6'b111111,
    parameter logic [5:0]  BG_RGB         = 6'b000000
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [5:0] FRAME_LAST   = 6'(REFRESH_FRAMES - 1);

    // Raster counters and refresh frame counter
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic [5:0] frame_q, frame_d;

    // Stage 1: decodes delayed one cycle to line up with pixel_in
    logic de_d1_q, de_d1_d;
    logic hs_d1_q, hs_d1_d;
    logic vs_d1_q, vs_d1_d;

    // Stage 2: registered pins
    logic       vga_hs_q, vga_hs_d;
    logic       vga_vs_q, vga_vs_d;
    logic [5:0] rgb_q, rgb_d;

    logic h_last, v_last;
    logic de_raw, hs_raw, vs_raw;

    always_comb begin
        h_last = (h_q == H_LAST);
        v_last = (v_q == V_LAST);
        de_raw = (h_q < H_ACT) && (v_q < V_ACT);
        hs_raw = (h_q >= H_SYNC_FIRST) && (h_q <= H_SYNC_LAST);
        vs_raw = (v_q >= V_SYNC_FIRST) && (v_q <= V_SYNC_LAST);
    end

    // NOTE: every variable assigned in this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        h_d     = h_q + 10'd1;
        v_d     = v_q;
        frame_d = frame_q;
        if (h_last) begin
            h_d = '0;
            if (v_last) begin
                v_d     = '0;
                frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 6'd1;
            end else begin
                v_d = v_q + 10'd1;
            end
        end
    end

    always_comb begin
        de_d1_d  = de_raw;
        hs_d1_d  = hs_raw;
        vs_d1_d  = vs_raw;
        vga_hs_d = hs_d1_q ? SYNC_POL : ~SYNC_POL;
        vga_vs_d = vs_d1_q ? SYNC_POL : ~SYNC_POL;
        rgb_d    = '0;
        if (de_d1_q) begin
            rgb_d = bus.pixel_in ? FG_RGB : BG_RGB;
        end
    end

    // NOTE: reset is synchronous, so it is only honoured on the clock edge; all state uses non-blocking <=.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q      <= '0;
            v_q      <= '0;
            frame_q  <= '0;
            de_d1_q  <= 1'b0;
            hs_d1_q  <= 1'b0;
            vs_d1_q  <= 1'b0;
            vga_hs_q <= ~SYNC_POL;
            vga_vs_q <= ~SYNC_POL;
            rgb_q    <= '0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            frame_q  <= frame_d;
            de_d1_q  <= de_d1_d;
            hs_d1_q  <= hs_d1_d;
            vs_d1_q  <= vs_d1_d;
            vga_hs_q <= vga_hs_d;
            vga_vs_q <= vga_vs_d;
            rgb_q    <= rgb_d;
        end
    end

    // Strobes are gated by reset so the renderer never sees a start while held.
    assign bus.horizCounter = h_q;
    assign bus.vertCounter  = v_q;
    assign bus.display_on   = de_raw;
    assign bus.line_start   = (h_q == '0) && !reset;
    assign bus.frame_start  = (h_q == '0) && (v_q == '0) && !reset;
    assign bus.refresh_req  = (frame_q == FRAME_LAST) && (v_q == V_ACT) && !reset;
    assign bus.vga_hs       = vga_hs_q;
    assign bus.vga_vs       = vga_vs_q;
    assign bus.vga_r        = rgb_q[5:4];
    assign bus.vga_g        = rgb_q[3:2];
    assign bus.vga_b        = rgb_q[1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster; the reference model derives
// every output from "cycles since reset release" with plain division and modulo.
module tb_vga_timing_gen;

    localparam int HA = 20, HF = 3, HS = 5, HB = 4;
    localparam int VA = 12, VF = 2, VS = 3, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int RF = 2;
    localparam logic       POL = 1'b0;
    localparam logic [5:0] FG  = 6'b110110;
    localparam logic [5:0] BG  = 6'b001001;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    vga_timing_gen_if bus();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL), .REFRESH_FRAMES(RF), .FG_RGB(FG), .BG_RGB(BG)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         h;
        int         v;
        logic       de;
        logic       ls;
        logic       fs;
        logic       rr;
        logic       hs;
        logic       vs;
        logic [5:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model history: raster position, reset and pixel of the previous two cycles.
    int   pos1 = 0, pos2 = 0;
    logic rst1 = 1'b1, rst2 = 1'b1, pix1 = 1'b0;
    logic rst_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock cycle: work out what the raster should show, drive inputs, queue the expectation.
    // mode 0: random pixel, 1: pixel only for the counters (5,10), 2: pixel always 1.
    task automatic step(input int mode, input logic force_rst, input int rst_at);
        exp_t e;
        int   pos, hq, vq;
        logic r, px;
        @(posedge clk);
        #1;
        pos = rst1 ? 0 : pos1 + 1;
        r   = force_rst || (rst_at >= 0 && pos == rst_at);
        if (r && !force_rst) rst_done = 1'b1;
        case (mode)
            1:       px = ((pos1 % HT) == 5) && (((pos1 / HT) % VT) == 10);
            2:       px = 1'b1;
            default: px = 1'($urandom_range(0, 1));
        endcase

        e.h  = pos % HT;
        e.v  = (pos / HT) % VT;
        e.de = (e.h < HA) && (e.v < VA);
        e.ls = (e.h == 0) && !r;
        e.fs = (e.h == 0) && (e.v == 0) && !r;
        e.rr = (((pos / FT) % RF) == RF - 1) && (e.v == VA) && !r;
        if (rst1 || rst2) begin
            e.hs  = ~POL;
            e.vs  = ~POL;
            e.rgb = '0;
        end else begin
            hq    = pos2 % HT;
            vq    = (pos2 / HT) % VT;
            e.hs  = (hq >= HA + HF && hq < HA + HF + HS) ? POL : ~POL;
            e.vs  = (vq >= VA + VF && vq < VA + VF + VS) ? POL : ~POL;
            e.rgb = (hq < HA && vq < VA) ? (pix1 ? FG : BG) : 6'b0;
        end

        reset        = r;
        bus.pixel_in = px;
        sb.push_back(e);
        pos2 = pos1;
        pos1 = pos;
        rst2 = rst1;
        rst1 = r;
        pix1 = px;
    endtask

    // Monitor: every cycle the DUT presents a full raster state; compare it mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("horizCounter", 32'(bus.horizCounter), 32'(e.h));
                check("vertCounter",  32'(bus.vertCounter),  32'(e.v));
                check("display_on",   32'(bus.display_on),   32'(e.de));
                check("line_start",   32'(bus.line_start),   32'(e.ls));
                check("frame_start",  32'(bus.frame_start),  32'(e.fs));
                check("refresh_req",  32'(bus.refresh_req),  32'(e.rr));
                check("vga_hs",       32'(bus.vga_hs),       32'(e.hs));
                check("vga_vs",       32'(bus.vga_vs),       32'(e.vs));
                check("vga_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(e.rgb));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int target, gap, len;
        bus.pixel_in = 1'b0;

        // Reset held 5 cycles, then four frames of random pixels (refresh in frames 1 and 3).
        repeat (5) step(0, 1'b1, -1);
        repeat (4 * FT) step(0, 1'b0, -1);

        // Single lit pixel at (5,10), then a frame of constant pixel_in.
        repeat (FT) step(1, 1'b0, -1);
        repeat (FT) step(2, 1'b0, -1);

        // One-cycle reset when the counters show (10,7) in the next frame.
        rst_done = 1'b0;
        target   = ((pos1 / FT) + 1) * FT + 7 * HT + 10;
        for (int i = 0; i < 3 * FT && !rst_done; i++) step(0, 1'b0, target);
        check("mid_frame_reset_applied", 32'(rst_done), 32'd1);
        repeat (4 * FT) step(0, 1'b0, -1);

        // A few random resets of random length at random points.
        for (int k = 0; k < 3; k++) begin
            gap = $urandom_range(1, FT);
            len = $urandom_range(1, 3);
            repeat (gap) step(0, 1'b0, -1);
            repeat (len) step(0, 1'b1, -1);
        end
        repeat (2 * FT) step(2, 1'b0, -1);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
